// File: rtl/operand_fetch_if.sv
// Handshake bundles for operand_fetch.
//   of_dec_if : decoder -> operand stage (valid/ready + decoded fields).
//               master = decoder, slave = operand stage.
//   of_ex_if  : operand stage -> execute (valid/ready + operands/control).
//               master = operand stage, slave = execute.
// Signal names carry the operand stage's point of view (_in / _out).

interface of_dec_if #(
  parameter int IMM_WIDTH = 32
);
  logic                 dec_valid_in;
  logic                 dec_ready_out;
  logic [4:0]           dec_rs1_in;
  logic [4:0]           dec_rs2_in;
  logic [4:0]           dec_rd_in;
  logic                 dec_rd_we_in;
  logic                 dec_is_load_in;
  logic [IMM_WIDTH-1:0] dec_imm_in;

  modport master (
    output dec_valid_in, dec_rs1_in, dec_rs2_in, dec_rd_in, dec_rd_we_in,
           dec_is_load_in, dec_imm_in,
    input  dec_ready_out
  );
  modport slave (
    input  dec_valid_in, dec_rs1_in, dec_rs2_in, dec_rd_in, dec_rd_we_in,
           dec_is_load_in, dec_imm_in,
    output dec_ready_out
  );
endinterface

interface of_ex_if #(
  parameter int W         = 64,
  parameter int IMM_WIDTH = 32
);
  logic                 ex_valid_out;
  logic                 ex_ready_in;
  logic [W-1:0]         ex_op1_out;
  logic [W-1:0]         ex_op2_out;
  logic [4:0]           ex_rd_out;
  logic                 ex_rd_we_out;
  logic                 ex_is_load_out;
  logic [IMM_WIDTH-1:0] ex_imm_out;

  modport master (
    output ex_valid_out, ex_op1_out, ex_op2_out, ex_rd_out, ex_rd_we_out,
           ex_is_load_out, ex_imm_out,
    input  ex_ready_in
  );
  modport slave (
    input  ex_valid_out, ex_op1_out, ex_op2_out, ex_rd_out, ex_rd_we_out,
           ex_is_load_out, ex_imm_out,
    output ex_ready_in
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: decode-to-execute operand stage.
//   - Drives RegFile read addresses straight from the decoder fields.
//   - Per source: x0 -> 0, else EX bypass, else WB bypass, else RegFile data.
//   - Stalls the decoder on load-use (EX holds a pending load to a source).
//   - Captures operands at accept into a 2-entry buffer (head + skid); EX
//     sees the head register only, so ex_* are registered and stable under
//     backpressure.
// Ports:
//   clk_in, reset_n (async low), flush_in (sync drop of buffer + offer)
//   dec   : of_dec_if.slave   decoder handshake and fields
//   rf_*  : RegFile read address out / read data in
//   ex_fwd_*, wb_* : bypass sources
//   ex    : of_ex_if.master   head entry to execute
//   hazard_out : load-use stall this cycle
// Optional (OPERAND_FETCH_STATS_EN): stall_cnt_out, issue_cnt_out, saturating,
//   cleared by reset only.

// One source operand select. rs==0 wins first, so rd==0 can never bypass.
module operand_sel #(
  parameter int W = 64
) (
  input  logic [4:0]   rs,
  input  logic [W-1:0] rf_data,
  input  logic         ex_valid,
  input  logic [4:0]   ex_rd,
  input  logic [W-1:0] ex_data,
  input  logic         wb_we,
  input  logic [4:0]   wb_rd,
  input  logic [W-1:0] wb_data,
  output logic [W-1:0] op
);
  always_comb begin
    if (rs == 5'd0)                   op = '0;
    else if (ex_valid && ex_rd == rs) op = ex_data;
    else if (wb_we && wb_rd == rs)    op = wb_data;
    else                              op = rf_data;
  end
endmodule

module operand_fetch #(
  parameter  int REG_DATA_WIDTH_POW = 6,
  parameter  int IMM_WIDTH          = 32,
  localparam int W                  = 1 << REG_DATA_WIDTH_POW
) (
  input  logic         clk_in,
  input  logic         reset_n,
  input  logic         flush_in,
  of_dec_if.slave      dec,
  output logic [4:0]   rf_rs1_out,
  output logic [4:0]   rf_rs2_out,
  input  logic [W-1:0] rf_data1_in,
  input  logic [W-1:0] rf_data2_in,
  input  logic         ex_fwd_valid_in,
  input  logic         ex_fwd_pend_in,
  input  logic [4:0]   ex_fwd_rd_in,
  input  logic [W-1:0] ex_fwd_data_in,
  input  logic         wb_we_in,
  input  logic [4:0]   wb_rd_in,
  input  logic [W-1:0] wb_data_in,
  of_ex_if.master      ex,
  output logic         hazard_out
`ifdef OPERAND_FETCH_STATS_EN
  ,
  output logic [31:0]  stall_cnt_out,
  output logic [31:0]  issue_cnt_out
`endif
);
  localparam int NUM_SRC = 2;

  typedef struct packed {
    logic [W-1:0]         op1;
    logic [W-1:0]         op2;
    logic [4:0]           rd;
    logic                 rd_we;
    logic                 is_load;
    logic [IMM_WIDTH-1:0] imm;
  } entry_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t state;
  entry_t head, skid, new_ent;

  logic [NUM_SRC-1:0][4:0]   src_rs;
  logic [NUM_SRC-1:0][W-1:0] src_rf;
  logic [NUM_SRC-1:0][W-1:0] src_op;
  logic                      accept, pop;

  assign rf_rs1_out = dec.dec_rs1_in;
  assign rf_rs2_out = dec.dec_rs2_in;

  assign src_rs = {dec.dec_rs2_in, dec.dec_rs1_in};
  assign src_rf = {rf_data2_in, rf_data1_in};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    operand_sel #(.W(W)) u_sel (
      .rs       (src_rs[g]),
      .rf_data  (src_rf[g]),
      .ex_valid (ex_fwd_valid_in),
      .ex_rd    (ex_fwd_rd_in),
      .ex_data  (ex_fwd_data_in),
      .wb_we    (wb_we_in),
      .wb_rd    (wb_rd_in),
      .wb_data  (wb_data_in),
      .op       (src_op[g])
    );
  end

  // Pending load in EX feeding either source: hold the decoder until the
  // data becomes forwardable (pend drops).
  assign hazard_out = dec.dec_valid_in && ex_fwd_pend_in && (ex_fwd_rd_in != 5'd0) &&
                      (dec.dec_rs1_in == ex_fwd_rd_in || dec.dec_rs2_in == ex_fwd_rd_in);

  assign dec.dec_ready_out = !hazard_out && (state != S_TWO) && !flush_in;
  assign accept            = dec.dec_valid_in && dec.dec_ready_out;
  assign pop               = ex.ex_valid_out && ex.ex_ready_in;

  always_comb begin
    new_ent         = '0;
    new_ent.op1     = src_op[0];
    new_ent.op2     = src_op[1];
    new_ent.rd      = dec.dec_rd_in;
    new_ent.rd_we   = dec.dec_rd_we_in;
    new_ent.is_load = dec.dec_is_load_in;
    new_ent.imm     = dec.dec_imm_in;
  end

  // Head only changes on pop or when filling an empty buffer, which keeps
  // ex_* stable while EX backpressures.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_EMPTY;
      head  <= '0;
      skid  <= '0;
    end else if (flush_in) begin
      state <= S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (accept) begin
          head  <= new_ent;
          state <= S_ONE;
        end
        S_ONE: begin
          if (accept && pop) begin
            head <= new_ent;
          end else if (accept) begin
            skid  <= new_ent;
            state <= S_TWO;
          end else if (pop) begin
            state <= S_EMPTY;
          end
        end
        S_TWO: if (pop) begin
          head  <= skid;
          state <= S_ONE;
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

  assign ex.ex_valid_out   = (state != S_EMPTY);
  assign ex.ex_op1_out     = head.op1;
  assign ex.ex_op2_out     = head.op2;
  assign ex.ex_rd_out      = head.rd;
  assign ex.ex_rd_we_out   = head.rd_we;
  assign ex.ex_is_load_out = head.is_load;
  assign ex.ex_imm_out     = head.imm;

`ifdef OPERAND_FETCH_STATS_EN
  // A pop in a flush cycle is discarded, so it is not counted as an issue.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_out <= '0;
      issue_cnt_out <= '0;
    end else begin
      if (hazard_out && stall_cnt_out != '1)          stall_cnt_out <= stall_cnt_out + 32'd1;
      if (pop && !flush_in && issue_cnt_out != '1)     issue_cnt_out <= issue_cnt_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;
  localparam int W   = 64;
  localparam int IMW = 32;

  logic           clk_in = 1'b0;
  logic           reset_n;
  logic           flush_in;
  logic [4:0]     rf_rs1_out, rf_rs2_out;
  logic [W-1:0]   rf_data1_in, rf_data2_in;
  logic           ex_fwd_valid_in, ex_fwd_pend_in;
  logic [4:0]     ex_fwd_rd_in;
  logic [W-1:0]   ex_fwd_data_in;
  logic           wb_we_in;
  logic [4:0]     wb_rd_in;
  logic [W-1:0]   wb_data_in;
  logic           hazard_out;
`ifdef OPERAND_FETCH_STATS_EN
  logic [31:0]    stall_cnt_out, issue_cnt_out;
`endif

  of_dec_if #(.IMM_WIDTH(IMW))        dec_if ();
  of_ex_if  #(.W(W), .IMM_WIDTH(IMW)) ex_if ();

  always #5 clk_in = ~clk_in;

  operand_fetch #(.REG_DATA_WIDTH_POW(6), .IMM_WIDTH(IMW)) dut (
    .clk_in          (clk_in),
    .reset_n         (reset_n),
    .flush_in        (flush_in),
    .dec             (dec_if),
    .rf_rs1_out      (rf_rs1_out),
    .rf_rs2_out      (rf_rs2_out),
    .rf_data1_in     (rf_data1_in),
    .rf_data2_in     (rf_data2_in),
    .ex_fwd_valid_in (ex_fwd_valid_in),
    .ex_fwd_pend_in  (ex_fwd_pend_in),
    .ex_fwd_rd_in    (ex_fwd_rd_in),
    .ex_fwd_data_in  (ex_fwd_data_in),
    .wb_we_in        (wb_we_in),
    .wb_rd_in        (wb_rd_in),
    .wb_data_in      (wb_data_in),
    .ex              (ex_if),
    .hazard_out      (hazard_out)
`ifdef OPERAND_FETCH_STATS_EN
    ,
    .stall_cnt_out   (stall_cnt_out),
    .issue_cnt_out   (issue_cnt_out)
`endif
  );

  // Reference model: an in-order queue of at most two captured entries.
  typedef struct {
    logic [W-1:0]   op1;
    logic [W-1:0]   op2;
    logic [4:0]     rd;
    logic           we;
    logic           ld;
    logic [IMW-1:0] imm;
  } ent_t;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  longint unsigned m_stall = 0, m_issue = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [4:0] rs, input logic [W-1:0] rf);
    if (rs == 0)                                         return '0;
    if (ex_fwd_valid_in && ex_fwd_rd_in == rs)           return ex_fwd_data_in;
    if (wb_we_in && wb_rd_in == rs)                      return wb_data_in;
    return rf;
  endfunction

  task automatic idle();
    flush_in = 0; dec_if.dec_valid_in = 0;
    dec_if.dec_rs1_in = 0; dec_if.dec_rs2_in = 0; dec_if.dec_rd_in = 0;
    dec_if.dec_rd_we_in = 0; dec_if.dec_is_load_in = 0; dec_if.dec_imm_in = 0;
    rf_data1_in = 0; rf_data2_in = 0;
    ex_fwd_valid_in = 0; ex_fwd_pend_in = 0; ex_fwd_rd_in = 0; ex_fwd_data_in = 0;
    wb_we_in = 0; wb_rd_in = 0; wb_data_in = 0;
    ex_if.ex_ready_in = 1;
  endtask

  // One clock: check every output at the falling edge against the model,
  // advance the model with this cycle's inputs, return 1 time unit after
  // the rising edge so the caller can drive the next cycle.
  task automatic cyc();
    ent_t e;
    logic haz_m, rdy_m, acc_m, pop_m;
    @(negedge clk_in);
    if (!reset_n) begin q.delete(); m_stall = 0; m_issue = 0; end
    haz_m = dec_if.dec_valid_in && ex_fwd_pend_in && ex_fwd_rd_in != 0 &&
            (dec_if.dec_rs1_in == ex_fwd_rd_in || dec_if.dec_rs2_in == ex_fwd_rd_in);
    rdy_m = !haz_m && q.size() < 2 && !flush_in;
    chk("hazard", {63'd0, hazard_out}, {63'd0, haz_m});
    chk("dec_ready", {63'd0, dec_if.dec_ready_out}, {63'd0, rdy_m});
    chk("rf_rs1", {59'd0, rf_rs1_out}, {59'd0, dec_if.dec_rs1_in});
    chk("rf_rs2", {59'd0, rf_rs2_out}, {59'd0, dec_if.dec_rs2_in});
    chk("ex_valid", {63'd0, ex_if.ex_valid_out}, {63'd0, q.size() != 0});
    if (q.size() != 0) begin
      chk("ex_op1", ex_if.ex_op1_out, q[0].op1);
      chk("ex_op2", ex_if.ex_op2_out, q[0].op2);
      chk("ex_rd", {59'd0, ex_if.ex_rd_out}, {59'd0, q[0].rd});
      chk("ex_rd_we", {63'd0, ex_if.ex_rd_we_out}, {63'd0, q[0].we});
      chk("ex_is_load", {63'd0, ex_if.ex_is_load_out}, {63'd0, q[0].ld});
      chk("ex_imm", {32'd0, ex_if.ex_imm_out}, {32'd0, q[0].imm});
    end
`ifdef OPERAND_FETCH_STATS_EN
    chk("stall_cnt", {32'd0, stall_cnt_out}, m_stall);
    chk("issue_cnt", {32'd0, issue_cnt_out}, m_issue);
`endif
    if (reset_n) begin
      acc_m = dec_if.dec_valid_in && rdy_m;
      pop_m = q.size() != 0 && ex_if.ex_ready_in;
      if (haz_m) m_stall++;
      e.op1 = ref_op(dec_if.dec_rs1_in, rf_data1_in);
      e.op2 = ref_op(dec_if.dec_rs2_in, rf_data2_in);
      e.rd  = dec_if.dec_rd_in;   e.we = dec_if.dec_rd_we_in;
      e.ld  = dec_if.dec_is_load_in; e.imm = dec_if.dec_imm_in;
      if (flush_in) q.delete();
      else begin
        if (pop_m) begin void'(q.pop_front()); m_issue++; end
        if (acc_m) q.push_back(e);
      end
    end
    @(posedge clk_in); #1;
  endtask

  task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2, input logic [IMW-1:0] imm);
    dec_if.dec_valid_in = 1; dec_if.dec_rs1_in = rs1; dec_if.dec_rs2_in = rs2;
    dec_if.dec_rd_in = rs1 + 5'd1; dec_if.dec_rd_we_in = 1; dec_if.dec_imm_in = imm;
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_valid"}, {63'd0, ex_if.ex_valid_out}, '0);
    chk({tag, "_op1"}, ex_if.ex_op1_out, '0);
    chk({tag, "_op2"}, ex_if.ex_op2_out, '0);
    chk({tag, "_ctl"}, {55'd0, ex_if.ex_rd_out, ex_if.ex_rd_we_out, ex_if.ex_is_load_out, 2'd0},
        '0);
    chk({tag, "_imm"}, {32'd0, ex_if.ex_imm_out}, '0);
    chk({tag, "_ready"}, {63'd0, dec_if.dec_ready_out}, 64'd1);
  endtask

  initial begin
    idle();
    reset_n = 0;
    #1;
    chk_zero_outs("reset");
    cyc(); cyc();
    reset_n = 1;

    // Bypass priority: EX > WB > RegFile.
    rf_data1_in = 64'h11; wb_we_in = 1; wb_rd_in = 5; wb_data_in = 64'h22;
    ex_fwd_valid_in = 1; ex_fwd_rd_in = 5; ex_fwd_data_in = 64'h33;
    offer(5, 6, 32'h100); cyc(); dec_if.dec_valid_in = 0;
    chk("byp_ex", ex_if.ex_op1_out, 64'h33);
    cyc();
    ex_fwd_valid_in = 0;
    offer(5, 6, 32'h101); cyc(); dec_if.dec_valid_in = 0;
    chk("byp_wb", ex_if.ex_op1_out, 64'h22);
    cyc();
    wb_we_in = 0;
    offer(5, 6, 32'h102); cyc(); dec_if.dec_valid_in = 0;
    chk("byp_rf", ex_if.ex_op1_out, 64'h11);
    cyc();

    // x0 source never bypasses.
    rf_data2_in = 64'h55; wb_we_in = 1; wb_rd_in = 0; wb_data_in = 64'hFF;
    ex_fwd_valid_in = 1; ex_fwd_rd_in = 0; ex_fwd_data_in = 64'hFF;
    offer(3, 0, 32'h200); cyc(); dec_if.dec_valid_in = 0;
    chk("x0_op2", ex_if.ex_op2_out, 64'h0);
    cyc();
    idle();

    // Load-use: two stall cycles, then accept with the forwarded load data.
    ex_fwd_pend_in = 1; ex_fwd_rd_in = 7;
    offer(7, 2, 32'h300);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("lu_hazard", {63'd0, hazard_out}, 64'd1);
      chk("lu_ready", {63'd0, dec_if.dec_ready_out}, 64'd0);
      cyc();
    end
    ex_fwd_pend_in = 0; ex_fwd_valid_in = 1; ex_fwd_data_in = 64'hABCD;
    cyc(); dec_if.dec_valid_in = 0; ex_fwd_valid_in = 0;
    chk("lu_data", ex_if.ex_op1_out, 64'hABCD);
    cyc();

    // Skid/backpressure: three offers with EX stalled, two accepted.
    ex_if.ex_ready_in = 0;
    offer(1, 2, 32'd1); cyc();
    offer(1, 2, 32'd2); cyc();
    offer(1, 2, 32'd3); #1;
    chk("skid_full_ready", {63'd0, dec_if.dec_ready_out}, 64'd0);
    cyc();
    dec_if.dec_valid_in = 0; ex_if.ex_ready_in = 1; #1;
    chk("skid_first", {32'd0, ex_if.ex_imm_out}, 64'd1);
    cyc();
    chk("skid_second", {32'd0, ex_if.ex_imm_out}, 64'd2);
    cyc();
    chk("skid_drained", {63'd0, ex_if.ex_valid_out}, 64'd0);

    // Flush with two entries while EX is ready: nothing issues.
    ex_if.ex_ready_in = 0;
    offer(4, 4, 32'd10); cyc(); offer(4, 4, 32'd11); cyc();
    dec_if.dec_valid_in = 1;
    ex_if.ex_ready_in = 1; flush_in = 1; cyc();
    flush_in = 0; dec_if.dec_valid_in = 0;
    chk("flush_valid", {63'd0, ex_if.ex_valid_out}, 64'd0);
    cyc();

    // Reset mid-traffic with two entries buffered.
    ex_if.ex_ready_in = 0;
    offer(9, 8, 32'd20); cyc(); offer(9, 8, 32'd21); cyc();
    dec_if.dec_valid_in = 0;
    reset_n = 0; #1;
    chk_zero_outs("midreset");
    cyc();
    reset_n = 1; ex_if.ex_ready_in = 1;
    cyc();

    // Randomized traffic on a small register range to hit many matches.
    for (int i = 0; i < 400; i++) begin
      dec_if.dec_valid_in    = ($urandom_range(0, 3) != 0);
      dec_if.dec_rs1_in      = 5'($urandom_range(0, 7));
      dec_if.dec_rs2_in      = 5'($urandom_range(0, 7));
      dec_if.dec_rd_in       = 5'($urandom_range(0, 31));
      dec_if.dec_rd_we_in    = 1'($urandom);
      dec_if.dec_is_load_in  = 1'($urandom);
      dec_if.dec_imm_in      = $urandom;
      rf_data1_in            = {$urandom, $urandom};
      rf_data2_in            = {$urandom, $urandom};
      ex_fwd_valid_in        = 1'($urandom);
      ex_fwd_pend_in         = ($urandom_range(0, 3) == 0);
      ex_fwd_rd_in           = 5'($urandom_range(0, 7));
      ex_fwd_data_in         = {$urandom, $urandom};
      wb_we_in               = 1'($urandom);
      wb_rd_in               = 5'($urandom_range(0, 7));
      wb_data_in             = {$urandom, $urandom};
      ex_if.ex_ready_in      = ($urandom_range(0, 2) != 0);
      flush_in               = ($urandom_range(0, 19) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
